// File: rtl/p3d_cpu_pkg.sv
// Shared types and constants for the P3D host CPU: opcodes, branch conditions,
// FSM states, VPU control-word field positions and the vector-bank RO index.
package p3d_cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_LLI = 4'h4, OP_LHI = 4'h5, OP_KEY = 4'h6, OP_LW  = 4'h7,
    OP_SW  = 4'h8, OP_B   = 4'h9, OP_JAL = 4'hA, OP_JR  = 4'hB,
    OP_MVV = 4'hC, OP_MVR = 4'hD, OP_VPU = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    BR_NE, BR_EQ, BR_GT, BR_LT, BR_GE, BR_LE, BR_OV, BR_ALWAYS
  } brcond_e;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_e;

  // Layout of the VPU control register selected by rb
  localparam int CTL_NUM_LSB   = 0;
  localparam int CTL_TYPE_LSB  = 5;
  localparam int CTL_COLOR_LSB = 7;
  localparam int CTL_FILL_BIT  = 10;

  localparam logic [3:0] RO_IDX = 4'd8;

  function automatic logic branch_taken(input logic [2:0] cond, input logic z,
                                        input logic n, input logic v);
    logic t;
    t = 1'b0;
    case (brcond_e'(cond))
      BR_NE:     t = !z;
      BR_EQ:     t = z;
      BR_GT:     t = !z && !n;
      BR_LT:     t = n;
      BR_GE:     t = !n;
      BR_LE:     t = n || z;
      BR_OV:     t = v;
      BR_ALWAYS: t = 1'b1;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/p3d_cpu_mem.sv
// Unified instruction/data word memory: one-cycle synchronous read, synchronous write.
// RAM may be preloaded from outside the design.
module cpu_mem #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] RAM [0:2**ADDR_W-1];

  always_ff @(posedge clk) begin
    if (we) RAM[addr] <= wdata;
    rdata <= RAM[addr];
  end

endmodule

// File: rtl/p3d_cpu.sv
// P3D host CPU: multicycle 16-bit core with key buffer and VPU vector/object bank.
// Optional macro CPU_KEY_RDCLR_EN: KEY clears key_reg after reading it.
module p3d_cpu
  import p3d_cpu_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        VPU_data_we,
  input  logic        VPU_rdy,
  input  logic [15:0] VPU_V0,
  input  logic [15:0] VPU_V1,
  input  logic [15:0] VPU_V2,
  input  logic [15:0] VPU_V3,
  input  logic [15:0] VPU_V4,
  input  logic [15:0] VPU_V5,
  input  logic [15:0] VPU_V6,
  input  logic [15:0] VPU_V7,
  input  logic [15:0] VPU_RO,
  input  logic        SPART_we,
  input  logic [12:0] SPART_keys,
  output logic        halt,
  output logic        start_VPU,
  output logic        fill_VPU,
  output logic [1:0]  obj_type_VPU,
  output logic [2:0]  obj_color_VPU,
  output logic [3:0]  op_VPU,
  output logic [3:0]  code_VPU,
  output logic [4:0]  obj_num_VPU,
  output logic [15:0] V0_VPU,
  output logic [15:0] V1_VPU,
  output logic [15:0] V2_VPU,
  output logic [15:0] V3_VPU,
  output logic [15:0] V4_VPU,
  output logic [15:0] V5_VPU,
  output logic [15:0] V6_VPU,
  output logic [15:0] V7_VPU,
  output logic [15:0] RO_VPU
);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx, pc_inc, mem_addr;
  logic [15:0]       rf [0:15];
  logic [15:0]       vbank [0:8];
  logic [12:0]       key_reg;
  logic              flag_z, flag_n, flag_v;

  logic [15:0]       mem_rdata, instr, ra_val, rb_val, rd_val, mvr_val;
  logic              mem_we, if_load;
  opcode_e           op;
  logic [3:0]        rd_idx, ra_idx, rb_idx;

  logic              wb_en, flags_we, mvv_we, vpu_fire, key_clr;
  logic [3:0]        wb_idx;
  logic [15:0]       wb_data;

  logic signed [15:0] op_a, op_b, sum, diff, alu_res;
  logic               alu_v;

  cpu_mem #(.ADDR_W(ADDR_W)) MEMORY (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (rd_val),
    .rdata (mem_rdata)
  );

  // Instruction register, kept in its own scope so it can be monitored as IF.IF_instr
  if (1) begin : IF
    logic [15:0] IF_instr;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       IF_instr <= '0;
      else if (if_load) IF_instr <= mem_rdata;
    end
  end

  // In EXEC the word arrives straight from memory; MEM works from the latched copy
  assign instr   = (state == EXEC) ? mem_rdata : IF.IF_instr;
  assign op      = opcode_e'(instr[15:12]);
  assign rd_idx  = instr[11:8];
  assign ra_idx  = instr[7:4];
  assign rb_idx  = instr[3:0];
  assign ra_val  = rf[ra_idx];
  assign rb_val  = rf[rb_idx];
  assign rd_val  = rf[rd_idx];
  assign mvr_val = (ra_idx <= RO_IDX) ? vbank[ra_idx] : 16'h0000;
  assign pc_inc  = pc + 1'b1;

  assign op_a = signed'(ra_val);
  assign op_b = signed'(rb_val);
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_v   = (op_a[15] == op_b[15]) && (sum[15] != op_a[15]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_v   = (op_a[15] != op_b[15]) && (diff[15] != op_a[15]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    mem_addr = pc;
    mem_we   = 1'b0;
    if_load  = 1'b0;
    wb_en    = 1'b0;
    wb_idx   = rd_idx;
    wb_data  = '0;
    flags_we = 1'b0;
    mvv_we   = 1'b0;
    vpu_fire = 1'b0;
    key_clr  = 1'b0;
    case (state)
      FETCH: state_nx = EXEC;
      EXEC: begin
        if_load  = 1'b1;
        pc_nx    = pc_inc;
        state_nx = FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            wb_en    = 1'b1;
            wb_data  = alu_res;
            flags_we = 1'b1;
          end
          OP_LLI: begin
            wb_en   = 1'b1;
            wb_data = {8'h00, instr[7:0]};
          end
          OP_LHI: begin
            wb_en   = 1'b1;
            wb_data = {instr[7:0], rd_val[7:0]};
          end
          OP_KEY: begin
            wb_en   = 1'b1;
            wb_data = {3'b000, key_reg};
`ifdef CPU_KEY_RDCLR_EN
            key_clr = 1'b1;
`else
            key_clr = 1'b0;
`endif
          end
          OP_LW: begin
            mem_addr = ADDR_W'(ra_val) + ADDR_W'({{12{rb_idx[3]}}, rb_idx});
            state_nx = MEM;
          end
          OP_SW: begin
            mem_addr = ADDR_W'(ra_val) + ADDR_W'({{12{rb_idx[3]}}, rb_idx});
            mem_we   = 1'b1;
          end
          OP_B: begin
            if (branch_taken(instr[10:8], flag_z, flag_n, flag_v))
              pc_nx = pc_inc + ADDR_W'({{8{instr[7]}}, instr[7:0]});
          end
          OP_JAL: begin
            wb_en   = 1'b1;
            wb_idx  = 4'd15;
            wb_data = 16'(pc_inc);
            pc_nx   = pc_inc + ADDR_W'({{4{instr[11]}}, instr[11:0]});
          end
          OP_JR:  pc_nx  = ADDR_W'(ra_val);
          OP_MVV: mvv_we = (rd_idx <= RO_IDX);
          OP_MVR: begin
            wb_en   = 1'b1;
            wb_data = mvr_val;
          end
          OP_VPU: begin
            // Stall in EXEC with PC held until the VPU reports idle
            if (!VPU_rdy) begin
              pc_nx    = pc;
              state_nx = EXEC;
            end else begin
              vpu_fire = 1'b1;
            end
          end
          OP_HLT:  state_nx = HALT;
          default: state_nx = FETCH;
        endcase
      end
      MEM: begin
        wb_en    = 1'b1;
        wb_data  = mem_rdata;
        state_nx = FETCH;
      end
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= ADDR_W'(RESET_PC);
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      for (int i = 0; i < 9; i++) vbank[i] <= '0;
      key_reg       <= '0;
      flag_z        <= 1'b0;
      flag_n        <= 1'b0;
      flag_v        <= 1'b0;
      start_VPU     <= 1'b0;
      op_VPU        <= '0;
      code_VPU      <= '0;
      obj_num_VPU   <= '0;
      obj_type_VPU  <= '0;
      obj_color_VPU <= '0;
      fill_VPU      <= 1'b0;
    end else begin
      pc <= pc_nx;
      if (wb_en && (wb_idx != 4'd0)) rf[wb_idx] <= wb_data;
      if (flags_we) begin
        flag_z <= (alu_res == 16'sd0);
        flag_n <= alu_res[15];
        flag_v <= alu_v;
      end
      // VPU result write-back wins over a simultaneous MVV
      if (VPU_data_we) begin
        vbank[0] <= VPU_V0;
        vbank[1] <= VPU_V1;
        vbank[2] <= VPU_V2;
        vbank[3] <= VPU_V3;
        vbank[4] <= VPU_V4;
        vbank[5] <= VPU_V5;
        vbank[6] <= VPU_V6;
        vbank[7] <= VPU_V7;
        vbank[8] <= VPU_RO;
      end else if (mvv_we) begin
        vbank[rd_idx] <= ra_val;
      end
      if (SPART_we)     key_reg <= SPART_keys;
      else if (key_clr) key_reg <= '0;
      start_VPU <= vpu_fire;
      if (vpu_fire) begin
        op_VPU        <= instr[11:8];
        code_VPU      <= instr[7:4];
        obj_num_VPU   <= rb_val[CTL_NUM_LSB +: 5];
        obj_type_VPU  <= rb_val[CTL_TYPE_LSB +: 2];
        obj_color_VPU <= rb_val[CTL_COLOR_LSB +: 3];
        fill_VPU      <= rb_val[CTL_FILL_BIT];
      end
    end
  end

  assign halt   = (state == HALT);
  assign V0_VPU = vbank[0];
  assign V1_VPU = vbank[1];
  assign V2_VPU = vbank[2];
  assign V3_VPU = vbank[3];
  assign V4_VPU = vbank[4];
  assign V5_VPU = vbank[5];
  assign V6_VPU = vbank[6];
  assign V7_VPU = vbank[7];
  assign RO_VPU = vbank[RO_IDX];

endmodule

// File: tb/tb_p3d_cpu.sv
// Directed bench for p3d_cpu: small hand-assembled programs with hand-computed results.
module tb_p3d_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        VPU_data_we, VPU_rdy, SPART_we;
  logic [15:0] VPU_V0, VPU_V1, VPU_V2, VPU_V3, VPU_V4, VPU_V5, VPU_V6, VPU_V7, VPU_RO;
  logic [12:0] SPART_keys;
  logic        halt, start_VPU, fill_VPU;
  logic [1:0]  obj_type_VPU;
  logic [2:0]  obj_color_VPU;
  logic [3:0]  op_VPU, code_VPU;
  logic [4:0]  obj_num_VPU;
  logic [15:0] V0_VPU, V1_VPU, V2_VPU, V3_VPU, V4_VPU, V5_VPU, V6_VPU, V7_VPU, RO_VPU;

  int checks = 0;
  int failures = 0;
  logic [15:0] key2_exp;

  p3d_cpu #(.ADDR_W(12), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .VPU_data_we(VPU_data_we), .VPU_rdy(VPU_rdy),
    .VPU_V0(VPU_V0), .VPU_V1(VPU_V1), .VPU_V2(VPU_V2), .VPU_V3(VPU_V3),
    .VPU_V4(VPU_V4), .VPU_V5(VPU_V5), .VPU_V6(VPU_V6), .VPU_V7(VPU_V7),
    .VPU_RO(VPU_RO), .SPART_we(SPART_we), .SPART_keys(SPART_keys),
    .halt(halt), .start_VPU(start_VPU), .fill_VPU(fill_VPU),
    .obj_type_VPU(obj_type_VPU), .obj_color_VPU(obj_color_VPU),
    .op_VPU(op_VPU), .code_VPU(code_VPU), .obj_num_VPU(obj_num_VPU),
    .V0_VPU(V0_VPU), .V1_VPU(V1_VPU), .V2_VPU(V2_VPU), .V3_VPU(V3_VPU),
    .V4_VPU(V4_VPU), .V5_VPU(V5_VPU), .V6_VPU(V6_VPU), .V7_VPU(V7_VPU),
    .RO_VPU(RO_VPU)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] w);
    dut.MEMORY.RAM[a] = w;
  endtask

  // Assert reset, confirm every output is cleared asynchronously, blank low memory
  task automatic begin_reset();
    @(negedge clk);
    rst_n = 1'b0;
    VPU_data_we = 1'b0; VPU_rdy = 1'b1; SPART_we = 1'b0; SPART_keys = '0;
    VPU_V0 = '0; VPU_V1 = '0; VPU_V2 = '0; VPU_V3 = '0; VPU_V4 = '0;
    VPU_V5 = '0; VPU_V6 = '0; VPU_V7 = '0; VPU_RO = '0;
    #1;
    check("rst_halt", halt, 0);
    check("rst_start", start_VPU, 0);
    check("rst_vpufields", {fill_VPU, obj_type_VPU, obj_color_VPU, op_VPU, code_VPU, obj_num_VPU}, 0);
    check("rst_v0", V0_VPU, 0);
    check("rst_v7", V7_VPU, 0);
    check("rst_ro", RO_VPU, 0);
    for (int i = 0; i < 64; i++) wr(i, 16'h0000);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (halt !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("halt_reached", halt, 1);
  endtask

  initial begin
    // Arithmetic basics and halt timing
    begin_reset();
    wr(0, 16'h4105); wr(1, 16'h4203); wr(2, 16'h0312); wr(3, 16'hF000);
    release_reset();
    repeat (7) tick();
    check("halt_before_8", halt, 0);
    tick();
    check("halt_at_8", halt, 1);
    check("add_r3", dut.rf[3], 16'h0008);
    check("pc_after_hlt", dut.pc, 4);
    repeat (5) tick();
    check("pc_frozen", dut.pc, 4);
    check("halt_sticky", halt, 1);

    // Branches and flags
    begin_reset();
    wr(0, 16'h4105); wr(1, 16'h1311); wr(2, 16'h9102); wr(3, 16'h4411);
    wr(4, 16'h4422); wr(5, 16'h9001); wr(6, 16'h4533); wr(7, 16'h46FF);
    wr(8, 16'h567F); wr(9, 16'h4701); wr(10, 16'h0867); wr(11, 16'h9601);
    wr(12, 16'h4944); wr(13, 16'hF000);
    release_reset();
    wait_halt(60);
    check("beq_skipped", dut.rf[4], 16'h0000);
    check("bne_not_taken", dut.rf[5], 16'h0033);
    check("lhi_r6", dut.rf[6], 16'h7FFF);
    check("add_ovf_r8", dut.rf[8], 16'h8000);
    check("flag_v", dut.flag_v, 1);
    check("flag_n", dut.flag_n, 1);
    check("flag_z", dut.flag_z, 0);
    check("bov_skipped", dut.rf[9], 16'h0000);

    // Store / load, including a negative offset
    begin_reset();
    wr(0, 16'h4105); wr(1, 16'h420A); wr(2, 16'h8107); wr(3, 16'h7407);
    wr(4, 16'h812F); wr(5, 16'hF000);
    release_reset();
    repeat (12) tick();
    check("lw_halt_before_13", halt, 0);
    tick();
    check("lw_halt_at_13", halt, 1);
    check("lw_r4", dut.rf[4], 16'h0005);
    check("sw_mem7", dut.MEMORY.RAM[7], 16'h0005);
    check("sw_mem9_negofs", dut.MEMORY.RAM[9], 16'h0005);

    // Keyboard buffer
`ifdef CPU_KEY_RDCLR_EN
    key2_exp = 16'h0000;
`else
    key2_exp = 16'h1000;
`endif
    begin_reset();
    wr(0, 16'h6F96); wr(1, 16'h6E00); wr(2, 16'hF000);
    release_reset();
    SPART_we = 1'b1; SPART_keys = 13'h1000;
    tick();
    SPART_we = 1'b0; SPART_keys = 13'h0ABC;
    wait_halt(20);
    check("key_r15", dut.rf[15], 16'h1000);
    check("key_second", dut.rf[14], key2_exp);

    // Vector bank: VPU write-back versus MVV, MVR, write-back while halted
    begin_reset();
    wr(0, 16'h4112); wr(1, 16'hC010); wr(2, 16'hC110); wr(3, 16'hC810);
    wr(4, 16'h4607); wr(5, 16'hD520); wr(6, 16'hD690); wr(7, 16'hF000);
    release_reset();
    repeat (3) tick();
    VPU_data_we = 1'b1;
    VPU_V0 = 16'hABCD; VPU_V1 = 16'h1111; VPU_V2 = 16'h2222; VPU_V3 = 16'h3030;
    VPU_V4 = 16'h4444; VPU_V5 = 16'h5555; VPU_V6 = 16'h6666; VPU_V7 = 16'h7777;
    VPU_RO = 16'hEEEE;
    tick();
    VPU_data_we = 1'b0;
    check("vpu_we_beats_mvv", V0_VPU, 16'hABCD);
    wait_halt(30);
    check("v0_kept", V0_VPU, 16'hABCD);
    check("mvv_v1", V1_VPU, 16'h0012);
    check("mvv_ro", RO_VPU, 16'h0012);
    check("v2_from_vpu", V2_VPU, 16'h2222);
    check("v7_from_vpu", V7_VPU, 16'h7777);
    check("mvr_v2", dut.rf[5], 16'h2222);
    check("mvr_idx9_zero", dut.rf[6], 16'h0000);
    VPU_data_we = 1'b1; VPU_V3 = 16'h3333;
    tick();
    VPU_data_we = 1'b0;
    check("vpu_we_in_halt", V3_VPU, 16'h3333);

    // VPU launch with stall
    begin_reset();
    wr(0, 16'h4285); wr(1, 16'h5204); wr(2, 16'hE322); wr(3, 16'hF000);
    release_reset();
    VPU_rdy = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_start_while_busy", start_VPU, 0);
    end
    check("pc_held_in_stall", dut.pc, 2);
    VPU_rdy = 1'b1;
    tick();
    check("start_pulse", start_VPU, 1);
    check("op_vpu", op_VPU, 3);
    check("code_vpu", code_VPU, 2);
    check("obj_num", obj_num_VPU, 5);
    check("obj_type", obj_type_VPU, 0);
    check("obj_color", obj_color_VPU, 1);
    check("fill", fill_VPU, 1);
    tick();
    check("start_one_cycle", start_VPU, 0);
    check("op_vpu_held", op_VPU, 3);
    wait_halt(10);

    // JAL / JR
    begin_reset();
    wr(0, 16'hA002); wr(1, 16'hF000); wr(2, 16'h4144); wr(3, 16'h4133);
    wr(4, 16'hB0F0);
    release_reset();
    wait_halt(20);
    check("jal_link", dut.rf[15], 16'h0001);
    check("jal_target_r1", dut.rf[1], 16'h0033);
    check("jr_pc", dut.pc, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
